// File: rtl/button_event_gen_if.sv
// Button level input and per-channel event strobes between the debouncers,
// the event generator and the stopwatch control logic.
interface button_event_gen_if #(
    parameter int N_BTN = 2
);
    logic [N_BTN-1:0]   btn_level;
    logic [N_BTN-1:0]   press_pulse;
    logic [N_BTN-1:0]   release_pulse;
    logic [N_BTN-1:0]   long_pulse;
    logic [N_BTN-1:0]   repeat_pulse;
    logic [N_BTN-1:0]   held;
    logic [2*N_BTN-1:0] state_dbg;

    // Events are single-cycle strobes with no backpressure: a consumer must
    // act on a pulse in the cycle it is high; there is no valid/ready pair.
    modport master (
        input  btn_level,
        output press_pulse, release_pulse, long_pulse, repeat_pulse, held, state_dbg
    );

    modport slave (
        output btn_level,
        input  press_pulse, release_pulse, long_pulse, repeat_pulse, held, state_dbg
    );
endinterface

// File: rtl/button_event_gen.sv
// Turns debounced button levels into registered single-cycle press, release,
// long-press and auto-repeat events; one independent FSM and counter per button.
module button_event_gen #(
    parameter int N_BTN         = 2,
    parameter int HOLD_CYCLES   = 1_000_000,
    parameter int REPEAT_CYCLES = 250_000,
    parameter int CNT_W         = 20
) (
    input  logic               clk,
    input  logic               rst,
    button_event_gen_if.master bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    state_t           state_q [N_BTN];
    logic [CNT_W-1:0] cnt_q   [N_BTN];
    logic [N_BTN-1:0] armed_q;
    logic [N_BTN-1:0] press_q;
    logic [N_BTN-1:0] release_q;
    logic [N_BTN-1:0] long_q;
    logic [N_BTN-1:0] repeat_q;
    logic [N_BTN-1:0] held_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            armed_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            repeat_q  <= '0;
            held_q    <= '0;
        end else begin
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            repeat_q  <= '0;
            // A level stuck high out of reset must be seen low before it counts.
            armed_q   <= armed_q | ~bus.btn_level;
            for (int i = 0; i < N_BTN; i++) begin
                case (state_q[i])
                    IDLE: begin
                        if (bus.btn_level[i] && armed_q[i]) begin
                            state_q[i] <= PRESSED;
                            cnt_q[i]   <= '0;
                            press_q[i] <= 1'b1;
                            held_q[i]  <= 1'b1;
                        end
                    end
                    PRESSED: begin
                        // Release wins over a coincident threshold.
                        if (!bus.btn_level[i]) begin
                            state_q[i]   <= IDLE;
                            cnt_q[i]     <= '0;
                            release_q[i] <= 1'b1;
                            held_q[i]    <= 1'b0;
                        end else if (cnt_q[i] == HOLD_LAST) begin
                            state_q[i] <= LONG;
                            cnt_q[i]   <= '0;
                            long_q[i]  <= 1'b1;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + 1'b1;
                        end
                    end
                    LONG: begin
                        if (!bus.btn_level[i]) begin
                            state_q[i]   <= IDLE;
                            cnt_q[i]     <= '0;
                            release_q[i] <= 1'b1;
                            held_q[i]    <= 1'b0;
                        end else if (cnt_q[i] == REPEAT_LAST) begin
                            cnt_q[i]    <= '0;
                            repeat_q[i] <= 1'b1;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + 1'b1;
                        end
                    end
                    default: begin
                        state_q[i] <= IDLE;
                        cnt_q[i]   <= '0;
                        held_q[i]  <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        bus.state_dbg = '0;
        for (int i = 0; i < N_BTN; i++) begin
            bus.state_dbg[2*i +: 2] = state_q[i];
        end
    end

    assign bus.press_pulse   = press_q;
    assign bus.release_pulse = release_q;
    assign bus.long_pulse    = long_q;
    assign bus.repeat_pulse  = repeat_q;
    assign bus.held          = held_q;
endmodule
